// File: rtl/wide_add_pkg.sv
// Shared types and defaults for the chunked wide adder/subtractor.
// Provides the sequencer state encoding and default chunk geometry.
package wide_add_pkg;

  localparam int N_DEF = 4;
  localparam int K_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// N-bit ripple-carry adder shared by every chunk of a wide operation.
// Ports: A, B (N-bit addends), Cin (carry in), Sum (N-bit), Cout (carry out).
module n_bit_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  logic [N:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign Sum[i]  = A[i] ^ B[i] ^ c[i];
    assign c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[N];

endmodule

// File: rtl/wide_add_sequencer.sv
// W-bit add/sub built from one N-bit adder, one chunk per cycle, LSB first.
// Ports: clk, rst_n, start, sub, op_a, op_b in; busy, done, result, cout, ovf, zero out.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [N*K-1:0]   op_a,
  input  logic [N*K-1:0]   op_b,
  output logic             busy,
  output logic             done,
  output logic [N*K-1:0]   result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int W  = N * K;
  localparam int IW = $clog2(K);

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           zero_q, zero_d;

  logic [N-1:0]   a_ch;
  logic [N-1:0]   b_ch;
  logic [N-1:0]   add_sum;
  logic           add_co;
  logic [W-1:0]   res_new;
  logic           last;

  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int k = 0; k < K; k++) begin
      if (idx_q == IW'(k)) begin
        a_ch = a_q[k*N +: N];
        b_ch = b_q[k*N +: N];
      end
    end
  end

  n_bit_adder #(.N(N)) u_add (
    .A    (a_ch),
    .B    (b_ch),
    .Cin  (carry_q),
    .Sum  (add_sum),
    .Cout (add_co)
  );

  // Result with this cycle's chunk merged in, so zero sees the final word.
  always_comb begin
    res_new = res_q;
    for (int k = 0; k < K; k++) begin
      if (idx_q == IW'(k)) begin
        res_new[k*N +: N] = add_sum;
      end
    end
  end

  assign last = (idx_q == IW'(K - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          // Subtraction is A + ~B + 1: invert B, inject 1 as chunk-0 carry.
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_new;
        carry_d = add_co;
        if (last) begin
          idx_d   = '0;
          cout_d  = add_co;
          ovf_d   = (a_q[W-1] == b_q[W-1]) &&
                    (add_sum[N-1] != a_q[W-1]);
          zero_d  = (res_new == '0);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer with directed vectors.
// Stimulus pushes expectations; a negedge monitor pops them on done.
module tb_wide_add_sequencer;

  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int busy_cnt = 0;
  int done_total = 0;
  int exp_total = 0;

  wide_add_sequencer #(.N(N), .K(K)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && start && !busy) acc_cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!busy) busy_cnt = 0;
    else busy_cnt++;
    if (done) begin
      done_total++;
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done expected none");
      end else begin
        e = q.pop_front();
        chk("result", int'(result), int'(e.r));
        chk("flags_cov_z", int'({cout, ovf, zero}),
            int'({e.c, e.o, e.z}));
        chk("latency", cyc - acc_cyc, K);
        chk("busy_cycles", busy_cnt, K + 1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_op(logic [15:0] a, logic [15:0] b,
                        logic s, exp_t x);
    wait_idle();
    op_a = a;
    op_b = b;
    sub = s;
    start = 1'b1;
    q.push_back(x);
    exp_total++;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int d0;
    int bad;
    int dc[3];

    repeat (2) @(negedge clk);
    chk("rst_result", int'(result), 0);
    chk("rst_ctrl", int'({busy, done, cout, ovf, zero}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h0FF0, 1'b0, '{16'h2224, 1'b0, 1'b0, 1'b0});
    run_op(16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1});
    run_op(16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0});
    run_op(16'h0005, 16'h0007, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0});
    run_op(16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0});

    // Abort mid-RUN with asynchronous reset.
    op_a = 16'hABCD;
    op_b = 16'h1234;
    sub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_result", int'(result), 0);
    chk("abort_ctrl", int'({busy, done, cout, ovf, zero}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", done_total, exp_total);
    run_op(16'h00FF, 16'h0001, 1'b0, '{16'h0100, 1'b0, 1'b0, 1'b0});

    // start held and op_a changed during RUN.
    wait_idle();
    d0 = done_total;
    op_a = 16'h0001;
    op_b = 16'h0001;
    sub = 1'b0;
    start = 1'b1;
    q.push_back('{16'h0002, 1'b0, 1'b0, 1'b0});
    exp_total++;
    @(negedge clk);
    op_a = 16'hAAAA;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    start = 1'b0;
    @(negedge clk);
    chk("no_reaccept", int'(busy), 0);
    chk("one_done", done_total - d0, 1);

    // Back-to-back with start held high.
    wait_idle();
    op_a = 16'h0100;
    op_b = 16'h0011;
    sub = 1'b0;
    start = 1'b1;
    bad = 0;
    for (int j = 0; j < 3; j++) begin
      q.push_back('{16'h0111, 1'b0, 1'b0, 1'b0});
      exp_total++;
    end
    for (int j = 0; j < 3; j++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (j > 0 && !done &&
            (result != 16'h0111 || {cout, ovf, zero} != 3'b000))
          bad++;
      end while (!done && n < 20);
      if (!done) chk("b2b_timeout", 1, 0);
      dc[j] = cyc;
      if (j == 2) start = 1'b0;
    end
    chk("b2b_gap1", dc[1] - dc[0], K + 2);
    chk("b2b_gap2", dc[2] - dc[1], K + 2);
    chk("b2b_stable", bad, 0);
    @(negedge clk);
    chk("b2b_stop", int'(busy), 0);

    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("done_count", done_total, exp_total);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
